// File: rtl/pkt2msg_arbiter_pkg.sv
// pkt2msg_arbiter_pkg: shared packet geometry and slot-state encoding
package pkt2msg_arbiter_pkg;
  localparam int FLIT_WIDTH = 8;
  localparam int MAX_PACKET_LENGHT = 4;
  localparam int PKT_W = MAX_PACKET_LENGHT * FLIT_WIDTH;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
endpackage

// File: rtl/pkt2msg_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int N_BITS_REQ = 1
) (
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_BITS_REQ-1:0] ptr_i,
  input  logic                  en_i,
  output logic [N_REQ-1:0]      grant_o,
  output logic [N_BITS_REQ-1:0] idx_o,
  output logic                  any_o
);
  logic [N_BITS_REQ-1:0] j;
  // scanning farthest-first lets the nearest requester overwrite, so no found flag is needed
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (ptr_i > N_BITS_REQ'(N_REQ - 1 - k)) ? ptr_i - N_BITS_REQ'(N_REQ - k) : ptr_i + N_BITS_REQ'(k);
      if (en_i && req_i[j]) begin
        grant_o = '0;
        grant_o[j] = 1'b1;
        idx_o = j;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pkt2msg_arbiter.sv
// pkt2msg_arbiter: round-robin share of the packet-to-message stage
// with a one-entry output slot handed to the message builder.
module pkt2msg_arbiter
  import pkt2msg_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int N_BITS_REQ = 1,
  parameter int PKT_WIDTH = PKT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           r_pkt_to_msg_i,
  output logic [N_REQ-1:0]           g_pkt_to_msg_o,
  input  logic [N_REQ*PKT_WIDTH-1:0] pkt_links_i,
  output logic [PKT_WIDTH-1:0]       packet_o,
  output logic [N_BITS_REQ-1:0]      packet_src_o,
  output logic                       packet_valid_o,
  input  logic                       packet_ack_i
);
  slot_state_e state_q, state_d;
  logic [N_BITS_REQ-1:0] ptr_q, ptr_d, src_q, src_d, win;
  logic [PKT_WIDTH-1:0] pkt_q, pkt_d;
  logic can_grant, any;
  assign can_grant = !rst && (state_q == EMPTY || packet_ack_i);
  rr_arbiter #(.N_REQ(N_REQ), .N_BITS_REQ(N_BITS_REQ)) u_rr (
    .req_i(r_pkt_to_msg_i),
    .ptr_i(ptr_q),
    .en_i(can_grant),
    .grant_o(g_pkt_to_msg_o),
    .idx_o(win),
    .any_o(any)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  end
  always_comb state_d = any ? FULL : (state_q == FULL && packet_ack_i) ? EMPTY : state_q;
  always_comb packet_valid_o = state_q == FULL;
  // capture on the grant edge: the requester clears its buffer on that same edge
  always_comb begin
    ptr_d = any ? ((win == N_BITS_REQ'(N_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
    src_d = any ? win : src_q;
    pkt_d = pkt_q;
    for (int i = 0; i < N_REQ; i++)
      if (g_pkt_to_msg_o[i]) pkt_d = pkt_links_i[i*PKT_WIDTH +: PKT_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      src_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      src_q <= src_d;
    end
  end
  always_ff @(posedge clk) pkt_q <= pkt_d;
  assign packet_o = pkt_q;
  assign packet_src_o = src_q;
endmodule

// File: tb/tb_pkt2msg_arbiter.sv
// tb_pkt2msg_arbiter: directed plus random checks of 4- and 3-requester arbiters against a queue-free reference model
module tb_pkt2msg_arbiter;
  logic clk, rst, ack;
  logic [3:0] r4, g4;
  logic [2:0] r3, g3;
  logic [4*32-1:0] lk4;
  logic [3*32-1:0] lk3;
  logic [31:0] p4o, p3o;
  logic [1:0] s4o, s3o;
  logic v4o, v3o;
  int ncmp = 0, nfail = 0;
  logic m_v4 = 0, m_v3 = 0;
  int m_s4 = 0, m_s3 = 0, m_p4 = 0, m_p3 = 0;
  logic [31:0] m_k4, m_k3;

  pkt2msg_arbiter #(.N_REQ(4), .N_BITS_REQ(2), .PKT_WIDTH(32)) u4 (
    .clk(clk), .rst(rst), .r_pkt_to_msg_i(r4), .g_pkt_to_msg_o(g4), .pkt_links_i(lk4),
    .packet_o(p4o), .packet_src_o(s4o), .packet_valid_o(v4o), .packet_ack_i(ack));
  pkt2msg_arbiter #(.N_REQ(3), .N_BITS_REQ(2), .PKT_WIDTH(32)) u3 (
    .clk(clk), .rst(rst), .r_pkt_to_msg_i(r3), .g_pkt_to_msg_o(g3), .pkt_links_i(lk3),
    .packet_o(p3o), .packet_src_o(s3o), .packet_valid_o(v3o), .packet_ack_i(ack));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input int n, input logic [3:0] r, input int p);
    for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  function automatic logic [31:0] exp_grant(input int n, input logic [3:0] r, input int p, input logic v,
                                            input logic a, input logic rs);
    int w;
    w = pick(n, r, p);
    return (!rs && (!v || a) && w >= 0) ? 32'(1) << w : 32'd0;
  endfunction

  task automatic upd(input int n, input logic [3:0] r, input logic [127:0] lk, input logic a, input logic rs,
                     inout logic v, inout int s, inout int p, inout logic [31:0] k);
    int w;
    w = pick(n, r, p);
    if (rs) begin
      v = 0; s = 0; p = 0;
    end else if ((!v || a) && w >= 0) begin
      k = lk[w*32 +: 32]; s = w; v = 1; p = (w + 1) % n;
    end else if (v && a) v = 0;
  endtask

  task automatic step(input logic [3:0] r4v, input logic [2:0] r3v, input logic av, input logic rsv);
    r4 = r4v; r3 = r3v; ack = av; rst = rsv;
    lk4 = {$urandom, $urandom, $urandom, $urandom};
    lk3 = {$urandom, $urandom, $urandom};
    #2;
    chk("grant4", 32'(g4), exp_grant(4, r4v, m_p4, m_v4, av, rsv));
    chk("grant3", 32'(g3), exp_grant(3, {1'b0, r3v}, m_p3, m_v3, av, rsv));
    @(posedge clk);
    upd(4, r4v, 128'(lk4), av, rsv, m_v4, m_s4, m_p4, m_k4);
    upd(3, {1'b0, r3v}, 128'(lk3), av, rsv, m_v3, m_s3, m_p3, m_k3);
    #1;
    chk("valid4", 32'(v4o), 32'(m_v4));
    chk("src4", 32'(s4o), 32'(m_s4));
    chk("valid3", 32'(v3o), 32'(m_v3));
    chk("src3", 32'(s3o), 32'(m_s3));
    if (m_v4) chk("pkt4", p4o, m_k4);
    if (m_v3) chk("pkt3", p3o, m_k3);
  endtask

  initial begin
    r4 = 0; r3 = 0; ack = 0; rst = 1; lk4 = 0; lk3 = 0;
    step(4'b0000, 3'b000, 0, 1);
    step(4'b0011, 3'b011, 0, 1);
    step(4'b0001, 3'b001, 0, 0);
    step(4'b0000, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) step(4'b0011, 3'b011, 0, 0);
    step(4'b0011, 3'b011, 1, 0);
    for (int i = 0; i < 3; i++) step(4'b0011, 3'b011, 1, 0);
    step(4'b0100, 3'b100, 1, 0);
    step(4'b1001, 3'b101, 1, 0);
    step(4'b0000, 3'b000, 1, 0);
    step(4'b0001, 3'b001, 0, 0);
    step(4'b0010, 3'b010, 1, 0);
    step(4'b0011, 3'b011, 0, 1);
    step(4'b0011, 3'b011, 0, 0);
    step(4'b0000, 3'b000, 1, 0);
    step(4'b0000, 3'b000, 1, 0);
    step(4'b0000, 3'b000, 1, 0);
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
